// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencing controller for a CIC decimator (integrator chain, rate-change sampler, comb chain).
// Latency: comb_en one cycle after the R-th accepted sample; out_valid one cycle after a RUN-state comb_en.
// Backpressure: in_ready drops on the last sample of a block while an earlier output is still unconsumed.
//
// Ports:
//   clk, rstn      - clock (posedge) and asynchronous active-low reset
//   run            - level enable; rising into IDLE starts, low returns to IDLE
//   cfg_rate       - decimation ratio R, latched on start (0 is rejected with cfg_err)
//   in_valid/in_ready, integ_en - upstream sample handshake and integrator enable
//   comb_en        - one-cycle comb chain strobe per R accepted samples
//   ovf_in/ovf_sticky - datapath overflow, sampled on comb strobes, held until next start
//   out_valid/out_ready - decimated output handshake
//   cfg_err        - one-cycle pulse per start attempt with cfg_rate == 0
// Optional build macro CIC_CTRL_STATS_EN adds saturating out_count / drop_count outputs.
module cic_decim_ctrl #(
  parameter int RATE_W = 8,
  parameter int WARMUP = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              integ_en,
  output logic              comb_en,
  input  logic              ovf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf_sticky,
  output logic              cfg_err
`ifdef CIC_CTRL_STATS_EN
  ,
  output logic [15:0]       out_count,
  output logic [15:0]       drop_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // warm_cnt only needs to reach WARMUP-1; the RUN transition replaces the final increment.
  localparam int WC_W = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  state_t            state;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] phase;
  logic [WC_W-1:0]   warm_cnt;
  logic [RATE_W-1:0] last_phase;
  logic              active;
  logic              blocked;

  assign last_phase = rate_q - RATE_W'(1);
  assign active     = (state == ST_WARMUP) || (state == ST_RUN);
  // Holding off the block-closing sample guarantees the comb output register
  // is never reloaded while its previous value is still waiting downstream.
  assign blocked    = (phase == last_phase) && out_valid && !out_ready;
  assign in_ready   = active && !blocked;
  assign integ_en   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      rate_q     <= '0;
      phase      <= '0;
      warm_cnt   <= '0;
      comb_en    <= 1'b0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      comb_en <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            if (cfg_rate != '0) begin
              rate_q     <= cfg_rate;
              phase      <= '0;
              warm_cnt   <= '0;
              ovf_sticky <= 1'b0;
              out_valid  <= 1'b0;
              state      <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_WARMUP, ST_RUN: begin
          if (!run) begin
            // Stop: drop any pending output and partial block; comb_en stays at its 0 default.
            state     <= ST_IDLE;
            phase     <= '0;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
          end else begin
            if (integ_en) begin
              if (phase == last_phase) begin
                phase   <= '0;
                comb_en <= 1'b1;
              end else begin
                phase <= phase + RATE_W'(1);
              end
            end
            if (state == ST_WARMUP) begin
              // Strobes here only fill the comb delay lines; their outputs are discarded.
              if (comb_en) begin
                if (warm_cnt == WARM_LAST) begin
                  state <= ST_RUN;
                end else begin
                  warm_cnt <= warm_cnt + WC_W'(1);
                end
              end
            end else begin
              // A new comb result wins over a same-cycle consume.
              if (comb_en) begin
                out_valid <= 1'b1;
              end else if (out_ready) begin
                out_valid <= 1'b0;
              end
            end
          end
          if (comb_en && ovf_in) begin
            ovf_sticky <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CIC_CTRL_STATS_EN
  logic start_ok;
  assign start_ok = (state == ST_IDLE) && run && (cfg_rate != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_count  <= '0;
      drop_count <= '0;
    end else begin
      if (start_ok) begin
        out_count <= '0;
      end else if (out_valid && out_ready && (out_count != 16'hFFFF)) begin
        out_count <= out_count + 16'd1;
      end
      if (active && in_valid && !in_ready && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
`timescale 1ns/1ps
module tb_cic_decim_ctrl;

  localparam int RATE_W = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              run;
  logic              run1;
  logic [RATE_W-1:0] cfg_rate;
  logic              in_valid;
  logic              ovf_in;
  logic              out_ready;

  logic in_ready, integ_en, comb_en, out_valid, ovf_sticky, cfg_err;
  logic in_ready1, integ_en1, comb_en1, out_valid1, ovf_sticky1, cfg_err1;
`ifdef CIC_CTRL_STATS_EN
  logic [15:0] out_count, drop_count, out_count1, drop_count1;
`endif

  // Default configuration (WARMUP=3).
  cic_decim_ctrl #(.RATE_W(RATE_W), .WARMUP(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .cfg_rate   (cfg_rate),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .integ_en   (integ_en),
    .comb_en    (comb_en),
    .ovf_in     (ovf_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_sticky (ovf_sticky),
    .cfg_err    (cfg_err)
`ifdef CIC_CTRL_STATS_EN
    ,
    .out_count  (out_count),
    .drop_count (drop_count)
`endif
  );

  // No-warmup configuration, started by its own run1.
  cic_decim_ctrl #(.RATE_W(RATE_W), .WARMUP(0)) dut1 (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run1),
    .cfg_rate   (cfg_rate),
    .in_valid   (in_valid),
    .in_ready   (in_ready1),
    .integ_en   (integ_en1),
    .comb_en    (comb_en1),
    .ovf_in     (ovf_in),
    .out_valid  (out_valid1),
    .out_ready  (out_ready),
    .ovf_sticky (ovf_sticky1),
    .cfg_err    (cfg_err1)
`ifdef CIC_CTRL_STATS_EN
    ,
    .out_count  (out_count1),
    .drop_count (drop_count1)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int s, s2;

  // Expected cycle numbers of DUT output events.
  int comb_q[$];
  int out_q[$];
  int err_q[$];
  int comb1_q[$];
  int out1_q[$];

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: event at cyc %0d expected none", name, cyc);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every observed output event must match the next expected cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (comb_en) begin
        if (comb_q.size() == 0) unexpected("comb_en");
        else chkn("comb_en_cyc", cyc, comb_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) unexpected("out_hs");
        else chkn("out_hs_cyc", cyc, out_q.pop_front());
      end
      if (cfg_err) begin
        if (err_q.size() == 0) unexpected("cfg_err");
        else chkn("cfg_err_cyc", cyc, err_q.pop_front());
      end
      if (comb_en1) begin
        if (comb1_q.size() == 0) unexpected("comb_en1");
        else chkn("comb_en1_cyc", cyc, comb1_q.pop_front());
      end
      if (out_valid1 && out_ready) begin
        if (out1_q.size() == 0) unexpected("out1_hs");
        else chkn("out1_hs_cyc", cyc, out1_q.pop_front());
      end
      if (cfg_err1) unexpected("cfg_err1");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end

  initial begin
    rstn = 1'b0; run = 1'b0; run1 = 1'b0; cfg_rate = '0;
    in_valid = 1'b0; ovf_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_integ_en", integ_en, 1'b0);
    chk1("rst_comb_en", comb_en, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_ovf_sticky", ovf_sticky, 1'b0);
    chk1("rst_cfg_err", cfg_err, 1'b0);
    rstn = 1'b1;
    goto_cyc(cyc + 1);

    // Continuous stream, R=4: strobes every 4 samples, outputs from the 4th strobe.
    cfg_rate = 8'd4; in_valid = 1'b1; out_ready = 1'b1; run = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= 6; k++) comb_q.push_back(s + 4 * k);
    for (int k = 4; k <= 6; k++) out_q.push_back(s + 4 * k + 1);
    goto_cyc(s + 6);  ovf_in = 1'b1;
    goto_cyc(s + 7);  ovf_in = 1'b0; chk1("ovf_nonstrobe", ovf_sticky, 1'b0);
    goto_cyc(s + 8);  chk1("comb_en_s8", comb_en, 1'b1); ovf_in = 1'b1;
    goto_cyc(s + 9);  ovf_in = 1'b0; chk1("ovf_strobe", ovf_sticky, 1'b1);
    goto_cyc(s + 16); chk1("no_out_in_warmup", out_valid, 1'b0);
    goto_cyc(s + 25); run = 1'b0;
    goto_cyc(s + 27);
    chk1("stop_in_ready", in_ready, 1'b0);
    chk1("ovf_held", ovf_sticky, 1'b1);
    in_valid = 1'b0;
    goto_cyc(s + 29);

    // Back-pressure, R=4: output stalls, last sample of the block is held off.
    in_valid = 1'b1; out_ready = 1'b1; run = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) comb_q.push_back(s + 4 * k);
    comb_q.push_back(s + 31);
    out_q.push_back(s + 17);
    out_q.push_back(s + 30);
    out_q.push_back(s + 32);
    goto_cyc(s);
    chk1("start_clears_ovf", ovf_sticky, 1'b0);
    chk1("start_in_ready", in_ready, 1'b1);
    goto_cyc(s + 18); out_ready = 1'b0;
    goto_cyc(s + 24); chk1("bp_in_ready_low", in_ready, 1'b0);
    goto_cyc(s + 30);
    chk1("bp_in_ready_held", in_ready, 1'b0);
    chk1("bp_out_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    goto_cyc(s + 31);
    chk1("bp_reopen", in_ready, 1'b1);
    chk1("bp_out_cleared", out_valid, 1'b0);
    goto_cyc(s + 32);
    run = 1'b0;
    chk1("stop_integ_en", integ_en, 1'b1);
    goto_cyc(s + 33);
    chk1("stop2_in_ready", in_ready, 1'b0);
    chk1("stop2_comb_en", comb_en, 1'b0);
    chk1("stop2_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    goto_cyc(s + 35);

    // cfg_rate == 0: error pulse per cycle of run, stays idle.
    cfg_rate = 8'd0; run = 1'b1;
    s = cyc + 1;
    err_q.push_back(s);
    err_q.push_back(s + 1);
    goto_cyc(s);     chk1("err_in_ready", in_ready, 1'b0);
    goto_cyc(s + 1); run = 1'b0; chk1("err_in_ready2", in_ready, 1'b0);
    goto_cyc(s + 2);

    // Then a normal R=2 start; a cfg_rate change while running is ignored.
    cfg_rate = 8'd2; in_valid = 1'b1; out_ready = 1'b1; run = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) comb_q.push_back(s + 2 * k);
    out_q.push_back(s + 9);
    out_q.push_back(s + 11);
    goto_cyc(s + 1);  cfg_rate = 8'd5;
    goto_cyc(s + 11); run = 1'b0;
    goto_cyc(s + 13); in_valid = 1'b0;
    goto_cyc(s + 15);

    // Async reset mid-RUN with an output pending and a partial block.
    cfg_rate = 8'd3; in_valid = 1'b1; out_ready = 1'b0; run = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= 4; k++) comb_q.push_back(s + 3 * k);
    goto_cyc(s + 3);  ovf_in = 1'b1;
    goto_cyc(s + 4);  ovf_in = 1'b0;
    goto_cyc(s + 13);
    chk1("pre_rst_out_valid", out_valid, 1'b1);
    chk1("pre_rst_in_ready", in_ready, 1'b1);
    chk1("pre_rst_ovf", ovf_sticky, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_comb_en", comb_en, 1'b0);
    chk1("arst_in_ready", in_ready, 1'b0);
    chk1("arst_ovf", ovf_sticky, 1'b0);
    chk1("arst_integ_en", integ_en, 1'b0);
    run = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 rstn = 1'b1;
    goto_cyc(cyc + 1);

    // Restart after reset: phase begins at 0, first strobe after 3 samples.
    in_valid = 1'b1; run = 1'b1;
    s2 = cyc + 1;
    comb_q.push_back(s2 + 3);
    goto_cyc(s2 + 3); run = 1'b0;
    goto_cyc(s2 + 4); in_valid = 1'b0;
    goto_cyc(s2 + 6);

    // R=1, no warmup: strobe after every sample, back-to-back outputs.
    cfg_rate = 8'd1; in_valid = 1'b1; out_ready = 1'b1; run1 = 1'b1;
    s = cyc + 1;
    for (int k = 1; k <= 4; k++) comb1_q.push_back(s + k);
    for (int k = 2; k <= 5; k++) out1_q.push_back(s + k);
    goto_cyc(s + 3);
    chk1("r1_in_ready", in_ready1, 1'b1);
    chk1("r1_out_valid", out_valid1, 1'b1);
    goto_cyc(s + 4); in_valid = 1'b0;
    goto_cyc(s + 6); run1 = 1'b0;
    goto_cyc(s + 8);

    chkn("comb_q_left", comb_q.size(), 0);
    chkn("out_q_left", out_q.size(), 0);
    chkn("err_q_left", err_q.size(), 0);
    chkn("comb1_q_left", comb1_q.size(), 0);
    chkn("out1_q_left", out1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
